// File: rtl/mem_pkg.sv
// Shared encodings for the memory stage: access sizes, FSM states and the
// completion tag that pairs each LSU command with its writeback.
package mem_pkg;

    localparam int unsigned XLEN  = 64;
    localparam int unsigned REG_W = 5;

    typedef enum logic [1:0] {
        SZ_BYTE  = 2'b00,
        SZ_HWORD = 2'b01,
        SZ_WORD  = 2'b10,
        SZ_DWORD = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ISSUE = 2'b01,
        ST_WAIT  = 2'b10
    } state_e;

    typedef struct packed {
        logic [REG_W-1:0] rd;
        logic             load;
        logic             nomem;
        size_e            size;
        logic             uns;
    } tag_t;

    // Natural alignment check on the low address bits.
    function automatic logic misaligned(size_e sz, logic [2:0] addr_lo);
        case (sz)
            SZ_HWORD: return addr_lo[0];
            SZ_WORD:  return |addr_lo[1:0];
            SZ_DWORD: return |addr_lo;
            default:  return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mem_stage_load_ext.sv
// Combinational sign/zero extension of right-justified load data.
module load_ext
    import mem_pkg::*;
(
    input  logic [63:0] dat_i,
    input  logic [1:0]  size_i,
    input  logic        unsigned_i,
    output logic [63:0] dat_o
);

    always_comb begin
        dat_o = dat_i;
        case (size_e'(size_i))
            SZ_BYTE:  dat_o = {{56{~unsigned_i & dat_i[7]}},  dat_i[7:0]};
            SZ_HWORD: dat_o = {{48{~unsigned_i & dat_i[15]}}, dat_i[15:0]};
            SZ_WORD:  dat_o = {{32{~unsigned_i & dat_i[31]}}, dat_i[31:0]};
            SZ_DWORD: dat_o = dat_i;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// Memory pipeline stage: accepts execute-stage ops, issues LSU commands and
// produces the writeback for loads and ALU pass-through ops.
module mem_stage
    import mem_pkg::*;
(
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        valid_i,
    output logic        ready_o,
    input  logic [63:0] addr_i,
    input  logic [63:0] dat_i,
    input  logic [4:0]  rd_i,
    input  logic        load_i,
    input  logic        store_i,
    input  logic [1:0]  size_i,
    input  logic        unsigned_i,
    output logic [63:0] lsu_addr_o,
    output logic [63:0] lsu_dat_o,
    output logic        lsu_we_o,
    output logic [1:0]  lsu_sel_o,
    output logic        lsu_nomem_o,
    output logic        lsu_hword_o,
    output logic        lsu_word_o,
    output logic        lsu_dword_o,
    input  logic        lsu_busy_i,
    input  logic        lsu_rwe_i,
    input  logic [63:0] lsu_dat_i,
    output logic        wb_we_o,
    output logic [4:0]  wb_rd_o,
    output logic [63:0] wb_dat_o,
    output logic        misalign_o
);

    state_e      r_state;
    state_e      w_state_next;
    tag_t        r_tag0;
    tag_t        r_tag1;
    logic [1:0]  r_tag_cnt;

    size_e       w_size;
    logic        w_accept;
    logic        w_is_mem;
    logic        w_misal;
    logic        w_cmd_load;
    logic        w_nomem_nxt;
    logic        w_hword_nxt;
    logic        w_word_nxt;
    logic        w_dword_nxt;
    logic        w_misal_nxt;
    logic [1:0]  w_sel;
    tag_t        w_tag_new;
    logic        w_pop;
    logic        w_wb_fire;
    logic [63:0] w_ext;

    assign w_size   = size_e'(size_i);
    assign ready_o  = (r_state == ST_IDLE);
    assign w_accept = valid_i && ready_o;
    assign w_is_mem = load_i || store_i;
    assign w_misal  = w_is_mem && misaligned(w_size, addr_i[2:0]);

    // State register.
    always_ff @(posedge clk_i) begin
        if (reset_i) r_state <= ST_IDLE;
        else         r_state <= w_state_next;
    end

    // Next-state logic; ALU ops and rejected accesses never leave IDLE.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:  if (w_accept && w_is_mem && !w_misal) w_state_next = ST_ISSUE;
            ST_ISSUE: w_state_next = ST_WAIT;
            ST_WAIT:  if (lsu_rwe_i) w_state_next = ST_IDLE;
            default:  w_state_next = ST_IDLE;
        endcase
    end

    // Next values of the registered command outputs and the completion tag.
    always_comb begin
        w_cmd_load  = 1'b0;
        w_nomem_nxt = 1'b0;
        w_hword_nxt = 1'b0;
        w_word_nxt  = 1'b0;
        w_dword_nxt = 1'b0;
        w_misal_nxt = 1'b0;
        w_sel       = 2'b00;
        w_tag_new   = '{rd: rd_i, load: load_i && !store_i, nomem: !w_is_mem,
                        size: SZ_DWORD, uns: 1'b0};
        if (w_accept) begin
            if (!w_is_mem) begin
                w_cmd_load  = 1'b1;
                w_nomem_nxt = 1'b1;
            end else if (w_misal) begin
                w_misal_nxt = 1'b1;
            end else begin
                w_cmd_load     = 1'b1;
                w_tag_new.size = w_size;
                w_tag_new.uns  = unsigned_i;
                w_sel          = 2'b11;
                case (w_size)
                    SZ_BYTE: begin
                        w_hword_nxt = 1'b1;
                        w_sel       = addr_i[0] ? 2'b10 : 2'b01;
                    end
                    SZ_HWORD: w_hword_nxt = 1'b1;
                    SZ_WORD:  w_word_nxt  = 1'b1;
                    SZ_DWORD: w_dword_nxt = 1'b1;
                endcase
            end
        end
    end

    // Oldest outstanding tag is retired by each LSU completion.
    assign w_pop     = lsu_rwe_i && (r_tag_cnt != 2'd0);
    assign w_wb_fire = w_pop && (r_tag0.load || r_tag0.nomem);

    load_ext u_load_ext (
        .dat_i      (lsu_dat_i),
        .size_i     (r_tag0.size),
        .unsigned_i (r_tag0.uns),
        .dat_o      (w_ext)
    );

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            lsu_addr_o  <= '0;
            lsu_dat_o   <= '0;
            lsu_we_o    <= 1'b0;
            lsu_sel_o   <= 2'b00;
            lsu_nomem_o <= 1'b0;
            lsu_hword_o <= 1'b0;
            lsu_word_o  <= 1'b0;
            lsu_dword_o <= 1'b0;
            misalign_o  <= 1'b0;
            wb_we_o     <= 1'b0;
            wb_rd_o     <= '0;
            wb_dat_o    <= '0;
            r_tag0      <= '0;
            r_tag1      <= '0;
            r_tag_cnt   <= 2'd0;
        end else begin
            lsu_nomem_o <= w_nomem_nxt;
            lsu_hword_o <= w_hword_nxt;
            lsu_word_o  <= w_word_nxt;
            lsu_dword_o <= w_dword_nxt;
            misalign_o  <= w_misal_nxt;
            wb_we_o     <= 1'b0;
            if (w_cmd_load) begin
                lsu_addr_o <= addr_i;
                lsu_dat_o  <= dat_i;
                lsu_we_o   <= store_i;
                lsu_sel_o  <= w_sel;
            end
            if (w_wb_fire) begin
                wb_we_o  <= (r_tag0.rd != 5'd0);
                wb_rd_o  <= r_tag0.rd;
                wb_dat_o <= w_ext;
            end
            case ({w_cmd_load, w_pop})
                2'b10: begin
                    if (r_tag_cnt == 2'd0) r_tag0 <= w_tag_new;
                    else                   r_tag1 <= w_tag_new;
                    r_tag_cnt <= r_tag_cnt + 2'd1;
                end
                2'b01: begin
                    r_tag0    <= r_tag1;
                    r_tag_cnt <= r_tag_cnt - 2'd1;
                end
                2'b11: begin
                    if (r_tag_cnt == 2'd1) begin
                        r_tag0 <= w_tag_new;
                    end else begin
                        r_tag0 <= r_tag1;
                        r_tag1 <= w_tag_new;
                    end
                end
                default: ;
            endcase
        end
    end

    // A new command must only be presented to an idle LSU.
    a_lsu_idle_on_issue: assert property (@(posedge clk_i) disable iff (reset_i)
        (r_state == ST_ISSUE) |-> !lsu_busy_i);

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage with a behavioural LSU responder and a
// writeback scoreboard checked by an independent monitor.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        reset_i = 1'b1;
    logic        valid_i = 1'b0;
    logic        ready_o;
    logic [63:0] addr_i = '0;
    logic [63:0] dat_i = '0;
    logic [4:0]  rd_i = '0;
    logic        load_i = 1'b0;
    logic        store_i = 1'b0;
    logic [1:0]  size_i = 2'b00;
    logic        unsigned_i = 1'b0;
    logic [63:0] lsu_addr_o;
    logic [63:0] lsu_dat_o;
    logic        lsu_we_o;
    logic [1:0]  lsu_sel_o;
    logic        lsu_nomem_o;
    logic        lsu_hword_o;
    logic        lsu_word_o;
    logic        lsu_dword_o;
    logic        lsu_busy_i = 1'b0;
    logic        lsu_rwe_i = 1'b0;
    logic [63:0] lsu_dat_i = '0;
    logic        wb_we_o;
    logic [4:0]  wb_rd_o;
    logic [63:0] wb_dat_o;
    logic        misalign_o;

    typedef struct {
        logic [4:0]  rd;
        logic [63:0] dat;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    int          n_chk = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          lsu_stall = 0;
    int          lsu_cnt = 0;
    logic [63:0] lsu_resp = '0;

    mem_stage dut (
        .clk_i       (clk),
        .reset_i     (reset_i),
        .valid_i     (valid_i),
        .ready_o     (ready_o),
        .addr_i      (addr_i),
        .dat_i       (dat_i),
        .rd_i        (rd_i),
        .load_i      (load_i),
        .store_i     (store_i),
        .size_i      (size_i),
        .unsigned_i  (unsigned_i),
        .lsu_addr_o  (lsu_addr_o),
        .lsu_dat_o   (lsu_dat_o),
        .lsu_we_o    (lsu_we_o),
        .lsu_sel_o   (lsu_sel_o),
        .lsu_nomem_o (lsu_nomem_o),
        .lsu_hword_o (lsu_hword_o),
        .lsu_word_o  (lsu_word_o),
        .lsu_dword_o (lsu_dword_o),
        .lsu_busy_i  (lsu_busy_i),
        .lsu_rwe_i   (lsu_rwe_i),
        .lsu_dat_i   (lsu_dat_i),
        .wb_we_o     (wb_we_o),
        .wb_rd_o     (wb_rd_o),
        .wb_dat_o    (wb_dat_o),
        .misalign_o  (misalign_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // LSU: ALU pass-through answers next cycle; memory ops after lsu_stall+1 busy cycles.
    always @(posedge clk) begin
        lsu_rwe_i <= 1'b0;
        if (reset_i) begin
            lsu_busy_i <= 1'b0;
            lsu_cnt    <= 0;
        end else if (lsu_nomem_o) begin
            lsu_rwe_i <= 1'b1;
            lsu_dat_i <= lsu_addr_o;
        end else if (lsu_hword_o || lsu_word_o || lsu_dword_o) begin
            lsu_busy_i <= 1'b1;
            lsu_cnt    <= lsu_stall;
        end else if (lsu_busy_i) begin
            if (lsu_cnt == 0) begin
                lsu_rwe_i  <= 1'b1;
                lsu_busy_i <= 1'b0;
                lsu_dat_i  <= lsu_resp;
            end else begin
                lsu_cnt <= lsu_cnt - 1;
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push(input logic [4:0] rd, input logic [63:0] dat, input int c);
        exp_t e;
        e.rd = rd; e.dat = dat; e.cyc = c;
        sb.push_back(e);
    endtask

    // Present one op for a single edge; returns the cycle count after acceptance.
    task automatic send(input logic ld, input logic st, input logic [1:0] sz, input logic uns,
                        input logic [4:0] rd, input logic [63:0] addr, input logic [63:0] dat,
                        output int acc);
        @(negedge clk);
        chk("ready_before_send", 64'(ready_o), 64'd1);
        valid_i = 1'b1; load_i = ld; store_i = st; size_i = sz; unsigned_i = uns;
        rd_i = rd; addr_i = addr; dat_i = dat;
        @(posedge clk);
        #1;
        valid_i = 1'b0;
        acc = cyc;
    endtask

    task automatic wait_idle(input string name);
        int i;
        i = 0;
        @(negedge clk);
        while (!ready_o && i < 60) begin
            @(negedge clk);
            i++;
        end
        chk(name, 64'(ready_o), 64'd1);
    endtask

    function automatic logic [63:0] ctrl_bits();
        return 64'({lsu_we_o, lsu_sel_o, lsu_nomem_o, lsu_hword_o, lsu_word_o, lsu_dword_o,
                    wb_we_o, wb_rd_o, misalign_o});
    endfunction

    // Writeback monitor: every wb_we_o must match the oldest expected entry.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset_i && wb_we_o) begin
                if (sb.size() == 0) begin
                    chk("wb_unexpected", 64'(wb_we_o), 64'd0);
                end else begin
                    e = sb.pop_front();
                    chk("wb_rd", 64'(wb_rd_o), 64'(e.rd));
                    chk("wb_dat", wb_dat_o, e.dat);
                    if (e.cyc >= 0) chk("wb_latency", 64'(cyc), 64'(e.cyc));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int a;
        int a2;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_addr", lsu_addr_o, 64'd0);
        chk("reset_dat", lsu_dat_o, 64'd0);
        chk("reset_ctrl", ctrl_bits(), 64'd0);
        chk("reset_wbdat", wb_dat_o, 64'd0);
        @(negedge clk);
        reset_i = 1'b0;
        @(posedge clk);
        #1;
        chk("ready_after_reset", 64'(ready_o), 64'd1);

        // Back-to-back ALU ops
        send(1'b0, 1'b0, 2'b11, 1'b0, 5'd5, 64'h11, 64'h0, a);
        chk("alu1_nomem", 64'(lsu_nomem_o), 64'd1);
        chk("alu1_addr", lsu_addr_o, 64'h11);
        chk("alu1_ready", 64'(ready_o), 64'd1);
        push(5'd5, 64'h11, a + 2);
        send(1'b0, 1'b0, 2'b11, 1'b0, 5'd6, 64'h22, 64'h0, a2);
        chk("alu2_nomem", 64'(lsu_nomem_o), 64'd1);
        chk("alu2_addr", lsu_addr_o, 64'h22);
        push(5'd6, 64'h22, a2 + 2);
        @(posedge clk);
        #1;
        chk("alu_nomem_drop", 64'(lsu_nomem_o), 64'd0);
        repeat (4) @(negedge clk);

        // Byte load at odd address, signed then unsigned
        lsu_stall = 1;
        lsu_resp  = 64'h0000_0000_0000_5A80;
        send(1'b1, 1'b0, 2'b00, 1'b0, 5'd7, 64'h1001, 64'h0, a);
        chk("lb_hword_pulse", 64'(lsu_hword_o), 64'd1);
        chk("lb_ctrl", 64'({lsu_we_o, lsu_sel_o, lsu_nomem_o, lsu_word_o, lsu_dword_o}),
            64'b0_10_000);
        chk("lb_addr", lsu_addr_o, 64'h1001);
        chk("lb_ready_low", 64'(ready_o), 64'd0);
        push(5'd7, 64'hFFFF_FFFF_FFFF_FF80, -1);
        wait_idle("lb_done");
        send(1'b1, 1'b0, 2'b00, 1'b1, 5'd8, 64'h1001, 64'h0, a);
        chk("lbu_sel", 64'(lsu_sel_o), 64'b10);
        push(5'd8, 64'h80, -1);
        wait_idle("lbu_done");

        // Dword store with stall; command fields must hold until completion
        lsu_stall = 3;
        send(1'b0, 1'b1, 2'b11, 1'b0, 5'd3, 64'h2000, 64'h0123_4567_89AB_CDEF, a);
        chk("sd_dword_pulse", 64'(lsu_dword_o), 64'd1);
        chk("sd_dat", lsu_dat_o, 64'h0123_4567_89AB_CDEF);
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (ready_o) break;
            chk("sd_hold_addr", lsu_addr_o, 64'h2000);
            chk("sd_hold_dat", lsu_dat_o, 64'h0123_4567_89AB_CDEF);
            chk("sd_hold_we_sel", 64'({lsu_we_o, lsu_sel_o}), 64'b1_11);
            if (k > 0)
                chk("sd_no_pulse", 64'({lsu_nomem_o, lsu_hword_o, lsu_word_o, lsu_dword_o}), 64'd0);
        end
        chk("sd_done", 64'(ready_o), 64'd1);
        repeat (2) @(negedge clk);

        // Halfword, word and dword loads with sign extension
        lsu_stall = 0;
        lsu_resp  = 64'hAAAA_BBBB_CCCC_8001;
        send(1'b1, 1'b0, 2'b01, 1'b0, 5'd11, 64'h10, 64'h0, a);
        chk("lh_sel", 64'(lsu_sel_o), 64'b11);
        push(5'd11, 64'hFFFF_FFFF_FFFF_8001, -1);
        wait_idle("lh_done");
        lsu_resp = 64'h1234_5678_8000_0001;
        send(1'b1, 1'b0, 2'b10, 1'b0, 5'd12, 64'h3004, 64'h0, a);
        chk("lw_word_pulse", 64'({lsu_hword_o, lsu_word_o, lsu_dword_o}), 64'b010);
        push(5'd12, 64'hFFFF_FFFF_8000_0001, -1);
        wait_idle("lw_done");
        lsu_resp = 64'hDEAD_BEEF_0000_0001;
        send(1'b1, 1'b0, 2'b11, 1'b0, 5'd13, 64'h18, 64'h0, a);
        push(5'd13, 64'hDEAD_BEEF_0000_0001, -1);
        wait_idle("ld_done");

        // Misaligned word and dword accesses are rejected
        send(1'b1, 1'b0, 2'b10, 1'b0, 5'd9, 64'h2002, 64'h0, a);
        chk("mis_w_pulse", 64'(misalign_o), 64'd1);
        chk("mis_w_nocmd", 64'({lsu_nomem_o, lsu_hword_o, lsu_word_o, lsu_dword_o}), 64'd0);
        chk("mis_w_ready", 64'(ready_o), 64'd1);
        @(posedge clk);
        #1;
        chk("mis_w_drop", 64'(misalign_o), 64'd0);
        send(1'b0, 1'b1, 2'b11, 1'b0, 5'd9, 64'h2004, 64'h5, a);
        chk("mis_d_pulse", 64'(misalign_o), 64'd1);
        chk("mis_d_ready", 64'(ready_o), 64'd1);
        repeat (2) @(negedge clk);

        // Load to x0 at even address: no writeback
        lsu_resp = 64'h7F;
        send(1'b1, 1'b0, 2'b00, 1'b0, 5'd0, 64'h1000, 64'h0, a);
        chk("lb_x0_sel", 64'(lsu_sel_o), 64'b01);
        wait_idle("lb_x0_done");
        repeat (3) @(negedge clk);

        // Reset while waiting on a word load abandons it
        lsu_stall = 20;
        lsu_resp  = 64'h1;
        send(1'b1, 1'b0, 2'b10, 1'b0, 5'd10, 64'h3000, 64'h0, a);
        repeat (3) @(negedge clk);
        chk("rst_in_wait", 64'(ready_o), 64'd0);
        reset_i = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_mid_addr", lsu_addr_o, 64'd0);
        chk("rst_mid_ctrl", ctrl_bits(), 64'd0);
        chk("rst_mid_wbdat", wb_dat_o, 64'd0);
        @(negedge clk);
        reset_i = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_mid_ready", 64'(ready_o), 64'd1);
        repeat (30) @(negedge clk);

        chk("sb_empty", 64'(sb.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
